// File: rtl/gs_host_emulator.sv
// GS host emulator: issues one test command, then drains and checksums raw samples.
// Optional GS_HOST_BYTESWAP_EN byte-swaps each captured sample.
module gs_host_emulator #(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int FIFO_RD_LAT    = 1
) (
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic        iStart,
  input  logic [31:0] i32Cmd,
  output logic        oCmdWrEn,
  output logic [31:0] o32CmdDin,
  input  logic        iCmdFull,
  output logic        oRawRdEn,
  input  logic [15:0] i16RawData,
  input  logic        iRawEmpty,
  output logic        oBusy,
  output logic        oDone,
  output logic        oTimeout,
  output logic [8:0]  o9Count,
  output logic [15:0] o16Checksum,
  output logic [15:0] o16LastSample
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_READ,
    S_DONE,
    S_ABORT
  } state_t;

  localparam logic [15:0] TO_MAX = 16'(TIMEOUT_CYCLES);
  localparam logic [1:0]  LAT    = 2'(FIFO_RD_LAT);

  state_t      state_q, state_n;
  logic [31:0] cmd_q, cmd_n;
  logic [8:0]  cnt_q, cnt_n;
  logic [15:0] csum_q, csum_n;
  logic [15:0] last_q, last_n;
  logic [15:0] to_q, to_n;
  logic [1:0]  lat_q, lat_n;
  logic        tout_q, tout_n;
  logic        wr_en, rd_en;
  logic [8:0]  target;
  logic [15:0] sample;

  // N of zero encodes a full 256-sample run
  assign target = (cmd_q[15:8] == 8'd0) ? 9'd256 : {1'b0, cmd_q[15:8]};

`ifdef GS_HOST_BYTESWAP_EN
  assign sample = {i16RawData[7:0], i16RawData[15:8]};
`else
  assign sample = i16RawData;
`endif

  always_comb begin
    state_n = state_q;
    cmd_n   = cmd_q;
    cnt_n   = cnt_q;
    csum_n  = csum_q;
    last_n  = last_q;
    to_n    = to_q;
    lat_n   = lat_q;
    tout_n  = tout_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (iStart) begin
          cmd_n   = i32Cmd;
          cnt_n   = 9'd0;
          csum_n  = 16'd0;
          last_n  = 16'd0;
          tout_n  = 1'b0;
          to_n    = 16'd0;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!iCmdFull) begin
          wr_en   = 1'b1;
          to_n    = 16'd0;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!iRawEmpty) begin
          rd_en   = 1'b1;
          to_n    = 16'd0;
          lat_n   = 2'd1;
          state_n = S_READ;
        end else begin
          to_n = to_q + 16'd1;
          if (to_n == TO_MAX) begin
            tout_n  = 1'b1;
            state_n = S_ABORT;
          end
        end
      end
      S_READ: begin
        // data becomes valid LAT cycles after the strobe
        if (lat_q >= LAT) begin
          last_n  = sample;
          csum_n  = csum_q + sample;
          cnt_n   = cnt_q + 9'd1;
          state_n = (cnt_n == target) ? S_DONE : S_WAIT;
        end else begin
          lat_n = lat_q + 2'd1;
        end
      end
      S_DONE:  state_n = S_IDLE;
      S_ABORT: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q <= S_IDLE;
      cmd_q   <= 32'd0;
      cnt_q   <= 9'd0;
      csum_q  <= 16'd0;
      last_q  <= 16'd0;
      to_q    <= 16'd0;
      lat_q   <= 2'd0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cmd_q   <= cmd_n;
      cnt_q   <= cnt_n;
      csum_q  <= csum_n;
      last_q  <= last_n;
      to_q    <= to_n;
      lat_q   <= lat_n;
      tout_q  <= tout_n;
    end
  end

  assign oCmdWrEn      = wr_en;
  assign oRawRdEn      = rd_en;
  assign o32CmdDin     = cmd_q;
  assign oBusy         = (state_q == S_ISSUE) || (state_q == S_WAIT) ||
                         (state_q == S_READ);
  assign oDone         = (state_q == S_DONE);
  assign oTimeout      = tout_q;
  assign o9Count       = cnt_q;
  assign o16Checksum   = csum_q;
  assign o16LastSample = last_q;

endmodule

// File: tb/tb_gs_host_emulator.sv
// Self-checking bench for gs_host_emulator: directed and random runs
// against a FIFO model and a sum/count reference model.
module tb_gs_host_emulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] cmd = 32'd0;
  logic        wren, rden, cmd_full = 1'b0;
  logic [31:0] din;
  logic [15:0] raw_data = 16'd0;
  logic        raw_empty;
  logic        busy, done, tout;
  logic [8:0]  count;
  logic [15:0] csum, last;

  always #5 clk = ~clk;

  gs_host_emulator #(.TIMEOUT_CYCLES(20), .FIFO_RD_LAT(1)) dut (
    .iClk(clk), .iReset_n(rst_n), .iStart(start), .i32Cmd(cmd),
    .oCmdWrEn(wren), .o32CmdDin(din), .iCmdFull(cmd_full),
    .oRawRdEn(rden), .i16RawData(raw_data), .iRawEmpty(raw_empty),
    .oBusy(busy), .oDone(done), .oTimeout(tout), .o9Count(count),
    .o16Checksum(csum), .o16LastSample(last)
  );

  logic [15:0] mem [0:1023];
  int rd_ptr = 0;
  int wr_ptr = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic [31:0] last_din = 32'd0;
  assign raw_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (rden) begin
      raw_data <= mem[rd_ptr[9:0]];
      rd_ptr   <= rd_ptr + 1;
      rd_cnt++;
    end
    if (wren) begin
      wr_cnt++;
      last_din = din;
    end
    if (done) done_cnt++;
  end

  int passed = 0;
  int total = 0;
  logic [15:0] stim[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] xf(input logic [15:0] d);
`ifdef GS_HOST_BYTESWAP_EN
    return {d[7:0], d[15:8]};
`else
    return d;
`endif
  endfunction

  task automatic push(input logic [15:0] d);
    mem[wr_ptr[9:0]] = d;
    wr_ptr++;
  endtask

  task automatic pulse_start(input logic [31:0] c);
    cmd   = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_case(input string tag, input logic [31:0] c);
    int tgt, nrx, w0, r0, d0;
    logic [15:0] sum, lst;
    logic fin;
    wr_ptr = rd_ptr;
    foreach (stim[i]) push(stim[i]);
    tgt = (c[15:8] == 8'd0) ? 256 : int'(c[15:8]);
    nrx = (stim.size() < tgt) ? stim.size() : tgt;
    sum = 16'd0;
    lst = 16'd0;
    for (int i = 0; i < nrx; i++) begin
      sum = sum + xf(stim[i]);
      lst = xf(stim[i]);
    end
    w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt;
    pulse_start(c);
    fin = 1'b0;
    for (int i = 0; i < 5000 && !fin; i++) begin
      if (done_cnt != d0 || tout) fin = 1'b1;
      else @(negedge clk);
    end
    check({tag, " finish"}, 32'(fin), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check({tag, " wren pulses"}, 32'(wr_cnt - w0), 32'd1);
    check({tag, " cmd din"}, last_din, c);
    check({tag, " rden pulses"}, 32'(rd_cnt - r0), 32'(nrx));
    check({tag, " done pulses"}, 32'(done_cnt - d0), 32'(nrx == tgt));
    check({tag, " timeout"}, 32'(tout), 32'(nrx != tgt));
    check({tag, " count"}, 32'(count), 32'(nrx));
    check({tag, " checksum"}, 32'(csum), 32'(sum));
    check({tag, " last"}, 32'(last), 32'(lst));
    check({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int w0, r0, k;
    logic [31:0] c;
    repeat (3) @(negedge clk);
    check("reset strobes", {18'd0, wren, rden, busy, done, tout, count},
          32'd0);
    check("reset din", din, 32'd0);
    check("reset csum", 32'(csum), 32'd0);
    check("reset last", 32'(last), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    stim = '{16'h0001, 16'h0002, 16'h0003, 16'hFFFF};
    run_case("t1", 32'h1A2B0403);

    stim = '{16'h1111, 16'h2222};
    wr_ptr = rd_ptr;
    foreach (stim[i]) push(stim[i]);
    w0 = wr_cnt;
    cmd_full = 1'b1;
    pulse_start(32'hAABB0209);
    repeat (9) @(negedge clk);
    check("full hold", 32'(wr_cnt - w0), 32'd0);
    cmd_full = 1'b0;
    #1 check("full drop wren", 32'(wren), 32'd1);
    @(negedge clk);
    check("full single wren", 32'(wr_cnt - w0), 32'd1);
    repeat (10) @(negedge clk);
    check("full count", 32'(count), 32'd2);

    stim = {};
    for (int i = 0; i < 256; i++) stim.push_back(16'h0100);
    run_case("t3", 32'h12340007);

    stim = '{16'h00AA, 16'h0055};
    run_case("t4", 32'h01020300);
    stim = '{16'h0007};
    wr_ptr = rd_ptr;
    push(16'h0001);
    push(16'h0002);
    r0 = rd_cnt;
    pulse_start(32'h00000300);
    check("t4 start clears tout", 32'(tout), 32'd0);
    for (int i = 0; i < 100 && rd_cnt - r0 < 2; i++) @(negedge clk);
    k = 0;
    while (!tout && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("t4 timeout latency", 32'(k >= 19 && k <= 23), 32'd1);
    repeat (2) @(negedge clk);

    wr_ptr = rd_ptr;
    w0 = wr_cnt;
    pulse_start(32'h00000300);
    repeat (4) @(negedge clk);
    push(16'h4242);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst strobes", {18'd0, wren, rden, busy, done, tout, count},
          32'd0);
    check("rst din", din, 32'd0);
    check("rst csum last", {csum, last}, 32'd0);
    w0 = wr_cnt;
    r0 = rd_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    push(16'h0001);
    push(16'h0002);
    repeat (6) @(negedge clk);
    check("rst no strobes", 32'((wr_cnt - w0) + (rd_cnt - r0)), 32'd0);
    check("rst count", 32'(count), 32'd0);

    wr_ptr = rd_ptr;
    w0 = wr_cnt;
    r0 = done_cnt;
    pulse_start(32'hC0DE0201);
    repeat (3) @(negedge clk);
    pulse_start(32'hBEEF0501);
    push(16'h0010);
    push(16'h0020);
    push(16'h0030);
    repeat (12) @(negedge clk);
    check("busy start din", din, 32'hC0DE0201);
    check("busy start wren", 32'(wr_cnt - w0), 32'd1);
    check("busy start done", 32'(done_cnt - r0), 32'd1);
    check("busy start count", 32'(count), 32'd2);

    stim = '{16'h3412};
    run_case("t6", 32'h00000100);
`ifdef GS_HOST_BYTESWAP_EN
    check("t6 swap last", 32'(last), 32'h1234);
`else
    check("t6 plain last", 32'(last), 32'h3412);
`endif

    for (int t = 0; t < 8; t++) begin
      int n, s;
      n = $urandom_range(1, 6);
      s = $urandom_range(0, n + 2);
      stim = {};
      for (int i = 0; i < s; i++) stim.push_back(16'($urandom));
      c = $urandom;
      c[15:8] = 8'(n);
      run_case($sformatf("rand%0d", t), c);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
